hazard_stall_ctr: RTL and testbench
===================================

Name: hazard_stall_ctr

Overview:
- Stall/flush controller for the 5-stage pipeline. It is the producer-side counterpart of the operand forwarding unit.
- Forwarding resolves RAW hazards by consuming results already in EX/MEM and MEM/WB. This block handles the cases forwarding cannot cover:
  - load-use distance 1;
  - multi-cycle data-memory access (freeze until mem_ready);
  - taken branch/jump resolved in EX (flush the wrong-path instructions).
- It drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB write enables and bubble controls, and keeps a stall statistics counter and a memory timeout watchdog.

Parameters:
- TIMEOUT_CYCLES, 255: MEM_WAIT cycles tolerated before mem_timeout is raised; range 1..65535.
- CNT_W, 16: width of stall_count.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- Id_Ex_memRead  input  1  instruction in EX is a load
- Id_Ex_writeRegAdd  input  5  destination register of instruction in EX
- If_Id_readReg1  input  5  rs of instruction in ID
- If_Id_readReg2  input  5  rt of instruction in ID
- If_Id_useReg1  input  1  ID instruction actually reads rs
- If_Id_useReg2  input  1  ID instruction actually reads rt
- Ex_branchTaken  input  1  branch/jump in EX is taken (PC redirect this cycle)
- Ex_Mem_memAccess  input  1  instruction in MEM performs a load/store
- mem_ready  input  1  data memory completes the access this cycle
- pcWrite  output  1  PC update enable
- If_Id_write  output  1  IF/ID register load enable
- If_Id_flush  output  1  IF/ID loads a NOP
- Id_Ex_write  output  1  ID/EX load enable
- Id_Ex_bubble  output  1  ID/EX loads a NOP (control bits zeroed)
- Ex_Mem_write  output  1  EX/MEM load enable
- Mem_Wb_bubble  output  1  MEM/WB loads a NOP
- stall_count  output  CNT_W  number of cycles in which pcWrite was 0, saturating
- mem_timeout  output  1  sticky watchdog error

Behaviour:
- States:
  - RUN: normal operation.
  - MEM_WAIT: a memory access is outstanding.
  - ERROR: watchdog fired.
- Hazard terms (combinational):
  - loaduse = Id_Ex_memRead && Id_Ex_writeRegAdd != 0 && ((If_Id_useReg1 && Id_Ex_writeRegAdd == If_Id_readReg1) || (If_Id_useReg2 && Id_Ex_writeRegAdd == If_Id_readReg2)).
  - memwait = Ex_Mem_memAccess && !mem_ready.
- Defaults:
  - pcWrite = If_Id_write = Id_Ex_write = Ex_Mem_write = 1.
  - If_Id_flush = Id_Ex_bubble = Mem_Wb_bubble = 0.
- All outputs are combinational from state and inputs, so they act in the same cycle. Priority (highest first): reset, ERROR, memwait, Ex_branchTaken, loaduse.
- rst_n = 0:
  - pcWrite = If_Id_write = Id_Ex_write = Ex_Mem_write = 0.
  - If_Id_flush = Id_Ex_bubble = Mem_Wb_bubble = 1.
  - At the clock edge: state <= RUN, stall_count <= 0, wait counter <= 0, mem_timeout <= 0.
  - Reset mid-MEM_WAIT or in ERROR behaves identically.
- memwait (RUN or MEM_WAIT):
  - All of pcWrite, If_Id_write, Id_Ex_write, Ex_Mem_write are 0; Mem_Wb_bubble = 1. The whole pipe freezes.
  - A simultaneous branch or load-use is ignored this cycle and re-evaluated after the freeze, because the inputs are held.
  - RUN -> MEM_WAIT and wait counter <= 1. Each further MEM_WAIT cycle increments it.
- MEM_WAIT with mem_ready = 1: normal/branch/load-use rules apply this cycle; state -> RUN; wait counter <= 0.
- Wait counter reaching TIMEOUT_CYCLES while memwait is still set: state -> ERROR, mem_timeout <= 1.
- ERROR: outputs are the same as the memwait freeze regardless of inputs. The only exit is reset.
- Ex_branchTaken (no memwait): pcWrite = 1, If_Id_flush = 1, Id_Ex_bubble = 1. Branch wins over load-use because the ID instruction is on the wrong path.
- loaduse (no memwait, no branch): pcWrite = 0, If_Id_write = 0, Id_Ex_bubble = 1. This lasts exactly one cycle, after which the load is in MEM and forwarding takes over.
- stall_count:
  - +1 on every non-reset cycle with pcWrite = 0.
  - Saturates at 2^CNT_W − 1 with no wrap.
- Register $0 never causes a stall.

Test Plan:
- Load-use: lw $5 in EX (memRead = 1, writeRegAdd = 5), ID reads rs = 5 with useReg1 = 1 -> one cycle with pcWrite = 0, If_Id_write = 0, Id_Ex_bubble = 1; next cycle defaults; stall_count = 1.
- Load into $0 with ID reading rs = 0, and load to $7 with ID rt = 7 but useReg2 = 0 -> no stall in either case; stall_count unchanged.
- Branch and load-use in the same cycle -> If_Id_flush = 1, Id_Ex_bubble = 1, pcWrite = 1; no stall.
- Ex_Mem_memAccess = 1, mem_ready low for 3 cycles then high -> 3 freeze cycles (all write enables 0, Mem_Wb_bubble = 1); 4th cycle defaults; state RUN; stall_count = 3.
- TIMEOUT_CYCLES = 4, mem_ready held 0 -> mem_timeout = 1 after 4 wait cycles; freeze persists when mem_ready later rises; rst_n = 0 for one cycle clears everything.
- Reset asserted in mid-MEM_WAIT -> during reset all enables 0, all bubbles/flush 1; after release state RUN, counters 0.
- stall_count saturation with CNT_W = 4 -> 20 stall cycles leave stall_count = 15.

Source files
------------

// File: rtl/hazard_stall_ctr_if.sv
// hazard_stall_ctr_if: hazard inputs and pipeline stall/flush controls between the pipeline and its stall controller.
interface hazard_stall_ctr_if #(parameter int CNT_W = 16);
    logic             Id_Ex_memRead;
    logic [4:0]       Id_Ex_writeRegAdd;
    logic [4:0]       If_Id_readReg1;
    logic [4:0]       If_Id_readReg2;
    logic             If_Id_useReg1;
    logic             If_Id_useReg2;
    logic             Ex_branchTaken;
    logic             Ex_Mem_memAccess;
    logic             mem_ready;
    logic             pcWrite;
    logic             If_Id_write;
    logic             If_Id_flush;
    logic             Id_Ex_write;
    logic             Id_Ex_bubble;
    logic             Ex_Mem_write;
    logic             Mem_Wb_bubble;
    logic [CNT_W-1:0] stall_count;
    logic             mem_timeout;
    modport master (
        output Id_Ex_memRead, Id_Ex_writeRegAdd, If_Id_readReg1, If_Id_readReg2,
               If_Id_useReg1, If_Id_useReg2, Ex_branchTaken, Ex_Mem_memAccess, mem_ready,
        input  pcWrite, If_Id_write, If_Id_flush, Id_Ex_write, Id_Ex_bubble,
               Ex_Mem_write, Mem_Wb_bubble, stall_count, mem_timeout
    );
    modport slave (
        input  Id_Ex_memRead, Id_Ex_writeRegAdd, If_Id_readReg1, If_Id_readReg2,
               If_Id_useReg1, If_Id_useReg2, Ex_branchTaken, Ex_Mem_memAccess, mem_ready,
        output pcWrite, If_Id_write, If_Id_flush, Id_Ex_write, Id_Ex_bubble,
               Ex_Mem_write, Mem_Wb_bubble, stall_count, mem_timeout
    );
endinterface

// File: rtl/hazard_stall_ctr.sv
// hazard_stall_ctr: load-use stall, memory-wait freeze and branch flush control with stall statistics and a memory watchdog.
module hazard_stall_ctr #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W = 16
) (
    input logic            clk,
    input logic            rst_n,
    hazard_stall_ctr_if.slave hz
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    state_t           state;
    logic [15:0]      waitCnt;
    logic [15:0]      nextWait;
    logic [CNT_W-1:0] stallCnt;
    logic             timeoutReg;
    logic             loadUse;
    logic             memWait;
    logic             freeze;
    logic             pcWr;
    always_comb begin
        loadUse  = hz.Id_Ex_memRead && hz.Id_Ex_writeRegAdd != 5'd0 &&
                   ((hz.If_Id_useReg1 && hz.Id_Ex_writeRegAdd == hz.If_Id_readReg1) ||
                    (hz.If_Id_useReg2 && hz.Id_Ex_writeRegAdd == hz.If_Id_readReg2));
        memWait  = hz.Ex_Mem_memAccess && !hz.mem_ready;
        freeze   = state == ERROR || memWait;
        nextWait = state == MEM_WAIT ? waitCnt + 16'd1 : 16'd1;
        // a taken branch overrides load-use: the stalled ID instruction is on the wrong path anyway
        pcWr     = rst_n && !freeze && (hz.Ex_branchTaken || !loadUse);
    end
    assign hz.pcWrite       = pcWr;
    assign hz.If_Id_write   = pcWr;
    assign hz.Id_Ex_write   = rst_n && !freeze;
    assign hz.Ex_Mem_write  = rst_n && !freeze;
    assign hz.Mem_Wb_bubble = !rst_n || freeze;
    assign hz.If_Id_flush   = !rst_n || (!freeze && hz.Ex_branchTaken);
    assign hz.Id_Ex_bubble  = !rst_n || (!freeze && (hz.Ex_branchTaken || loadUse));
    assign hz.stall_count   = stallCnt;
    assign hz.mem_timeout   = timeoutReg;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            waitCnt    <= '0;
            stallCnt   <= '0;
            timeoutReg <= 1'b0;
        end else begin
            if (!pcWr && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
            if (state != ERROR) begin
                if (memWait) begin
                    waitCnt <= nextWait;
                    state   <= nextWait >= TIMEOUT_LIM ? ERROR : MEM_WAIT;
                    if (nextWait >= TIMEOUT_LIM) timeoutReg <= 1'b1;
                end else begin
                    state   <= RUN;
                    waitCnt <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctr.sv
// tb_hazard_stall_ctr: scenario tasks with a queue of expected per-cycle controls, stall count and timeout.
module tb_hazard_stall_ctr;
    localparam logic [6:0] DEF = 7'b1101010;
    localparam logic [6:0] FRZ = 7'b0000001;
    localparam logic [6:0] RST = 7'b0010101;
    localparam logic [6:0] BR  = 7'b1111110;
    localparam logic [6:0] LU  = 7'b0001110;
    typedef struct packed {
        logic rstn, memRead;
        logic [4:0] wr, r1, r2;
        logic u1, u2, br, acc, rdy;
        logic [6:0] ctrl;
        logic to;
    } vec_t;
    typedef struct packed {
        logic [6:0] ctrl;
        logic [3:0] cnt;
        logic to;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n;
    exp_t sbq[$];
    vec_t tv[$];
    int compared = 0;
    int mismatched = 0;
    logic [3:0] mCnt = 4'd0;
    always #5 clk = ~clk;
    hazard_stall_ctr_if #(.CNT_W(4)) bus();
    hazard_stall_ctr #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .hz(bus));
    function automatic vec_t mk(logic rstn, logic memRead, logic [4:0] wr, logic [4:0] r1, logic [4:0] r2,
                                logic u1, logic u2, logic br, logic acc, logic rdy, logic [6:0] ctrl, logic to);
        return '{rstn, memRead, wr, r1, r2, u1, u2, br, acc, rdy, ctrl, to};
    endfunction
    function automatic vec_t idle(logic [6:0] ctrl, logic to);
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctrl, to);
    endfunction
    function automatic vec_t mem(logic rdy, logic [6:0] ctrl, logic to);
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 1, rdy, ctrl, to);
    endfunction
    function automatic exp_t observed();
        return '{{bus.pcWrite, bus.If_Id_write, bus.If_Id_flush, bus.Id_Ex_write, bus.Id_Ex_bubble,
                  bus.Ex_Mem_write, bus.Mem_Wb_bubble}, bus.stall_count, bus.mem_timeout};
    endfunction
    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        rst_n = v.rstn;
        bus.Id_Ex_memRead = v.memRead;
        bus.Id_Ex_writeRegAdd = v.wr;
        bus.If_Id_readReg1 = v.r1;
        bus.If_Id_readReg2 = v.r2;
        bus.If_Id_useReg1 = v.u1;
        bus.If_Id_useReg2 = v.u2;
        bus.Ex_branchTaken = v.br;
        bus.Ex_Mem_memAccess = v.acc;
        bus.mem_ready = v.rdy;
        sbq.push_back('{v.ctrl, mCnt, v.to});
        mCnt = !v.rstn ? 4'd0 : (!v.ctrl[6] && mCnt != 4'hF) ? mCnt + 4'd1 : mCnt;
    endtask
    task automatic test_reset();
        exp_t e, o;
        tv.delete();
        tv.push_back(mk(0, 1, 5, 5, 5, 1, 1, 1, 1, 0, RST, 0));
        tv.push_back(idle(DEF, 0));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(negedge clk);
            e = sbq.pop_front();
            o = observed();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL reset[%0d]: got ctrl=%b cnt=%0d to=%b, want ctrl=%b cnt=%0d to=%b", i, o.ctrl, o.cnt, o.to, e.ctrl, e.cnt, e.to);
            end
        end
    endtask
    task automatic test_load_use();
        exp_t e, o;
        tv.delete();
        tv.push_back(mk(1, 1, 5, 5, 0, 1, 0, 0, 0, 0, LU, 0));
        tv.push_back(idle(DEF, 0));
        tv.push_back(mk(1, 1, 9, 3, 9, 0, 1, 0, 0, 0, LU, 0));
        tv.push_back(idle(DEF, 0));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(negedge clk);
            e = sbq.pop_front();
            o = observed();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL load_use[%0d]: got ctrl=%b cnt=%0d to=%b, want ctrl=%b cnt=%0d to=%b", i, o.ctrl, o.cnt, o.to, e.ctrl, e.cnt, e.to);
            end
        end
    endtask
    task automatic test_no_stall();
        exp_t e, o;
        tv.delete();
        tv.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, DEF, 0));
        tv.push_back(mk(1, 1, 7, 1, 7, 1, 0, 0, 0, 0, DEF, 0));
        tv.push_back(mk(1, 0, 4, 4, 4, 1, 1, 0, 0, 0, DEF, 0));
        tv.push_back(idle(DEF, 0));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(negedge clk);
            e = sbq.pop_front();
            o = observed();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL no_stall[%0d]: got ctrl=%b cnt=%0d to=%b, want ctrl=%b cnt=%0d to=%b", i, o.ctrl, o.cnt, o.to, e.ctrl, e.cnt, e.to);
            end
        end
    endtask
    task automatic test_branch();
        exp_t e, o;
        tv.delete();
        tv.push_back(mk(1, 1, 5, 5, 0, 1, 0, 1, 0, 0, BR, 0));
        tv.push_back(idle(DEF, 0));
        tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ, 0));
        tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, BR, 0));
        tv.push_back(idle(DEF, 0));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(negedge clk);
            e = sbq.pop_front();
            o = observed();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL branch[%0d]: got ctrl=%b cnt=%0d to=%b, want ctrl=%b cnt=%0d to=%b", i, o.ctrl, o.cnt, o.to, e.ctrl, e.cnt, e.to);
            end
        end
    endtask
    task automatic test_mem_wait();
        exp_t e, o;
        tv.delete();
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0));
        for (int k = 0; k < 3; k++) tv.push_back(mem(0, FRZ, 0));
        tv.push_back(mem(1, DEF, 0));
        tv.push_back(idle(DEF, 0));
        tv.push_back(mk(1, 1, 5, 5, 0, 1, 0, 0, 1, 0, FRZ, 0));
        tv.push_back(mk(1, 1, 5, 5, 0, 1, 0, 0, 1, 1, LU, 0));
        tv.push_back(idle(DEF, 0));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(negedge clk);
            e = sbq.pop_front();
            o = observed();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL mem_wait[%0d]: got ctrl=%b cnt=%0d to=%b, want ctrl=%b cnt=%0d to=%b", i, o.ctrl, o.cnt, o.to, e.ctrl, e.cnt, e.to);
            end
        end
    endtask
    task automatic test_timeout();
        exp_t e, o;
        tv.delete();
        for (int k = 0; k < 4; k++) tv.push_back(mem(0, FRZ, 0));
        tv.push_back(mem(1, FRZ, 1));
        tv.push_back(mk(1, 1, 5, 5, 0, 1, 0, 1, 0, 0, FRZ, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 1));
        tv.push_back(idle(DEF, 0));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(negedge clk);
            e = sbq.pop_front();
            o = observed();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL timeout[%0d]: got ctrl=%b cnt=%0d to=%b, want ctrl=%b cnt=%0d to=%b", i, o.ctrl, o.cnt, o.to, e.ctrl, e.cnt, e.to);
            end
        end
    endtask
    task automatic test_reset_mid_wait();
        exp_t e, o;
        tv.delete();
        tv.push_back(mem(0, FRZ, 0));
        tv.push_back(mem(0, FRZ, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RST, 0));
        for (int k = 0; k < 3; k++) tv.push_back(mem(0, FRZ, 0));
        tv.push_back(mem(1, DEF, 0));
        tv.push_back(idle(DEF, 0));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(negedge clk);
            e = sbq.pop_front();
            o = observed();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL reset_mid_wait[%0d]: got ctrl=%b cnt=%0d to=%b, want ctrl=%b cnt=%0d to=%b", i, o.ctrl, o.cnt, o.to, e.ctrl, e.cnt, e.to);
            end
        end
    endtask
    task automatic test_back_to_back();
        exp_t e, o;
        tv.delete();
        tv.push_back(mk(1, 1, 3, 3, 0, 1, 0, 0, 0, 0, LU, 0));
        tv.push_back(mk(1, 1, 3, 3, 0, 1, 0, 1, 0, 0, BR, 0));
        tv.push_back(mk(1, 1, 3, 0, 3, 0, 1, 0, 0, 0, LU, 0));
        tv.push_back(mem(0, FRZ, 0));
        tv.push_back(mk(1, 1, 3, 3, 0, 1, 0, 0, 1, 1, LU, 0));
        tv.push_back(idle(DEF, 0));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(negedge clk);
            e = sbq.pop_front();
            o = observed();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL back_to_back[%0d]: got ctrl=%b cnt=%0d to=%b, want ctrl=%b cnt=%0d to=%b", i, o.ctrl, o.cnt, o.to, e.ctrl, e.cnt, e.to);
            end
        end
    endtask
    task automatic test_saturation();
        exp_t e, o;
        tv.delete();
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0));
        for (int k = 0; k < 20; k++) tv.push_back(mk(1, 1, 6, 6, 0, 1, 0, 0, 0, 0, LU, 0));
        tv.push_back(idle(DEF, 0));
        tv.push_back(idle(DEF, 0));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(negedge clk);
            e = sbq.pop_front();
            o = observed();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL saturation[%0d]: got ctrl=%b cnt=%0d to=%b, want ctrl=%b cnt=%0d to=%b", i, o.ctrl, o.cnt, o.to, e.ctrl, e.cnt, e.to);
            end
        end
    endtask
    initial begin
        rst_n = 1'b0;
        bus.Id_Ex_memRead = 1'b0;
        bus.Id_Ex_writeRegAdd = 5'd0;
        bus.If_Id_readReg1 = 5'd0;
        bus.If_Id_readReg2 = 5'd0;
        bus.If_Id_useReg1 = 1'b0;
        bus.If_Id_useReg2 = 1'b0;
        bus.Ex_branchTaken = 1'b0;
        bus.Ex_Mem_memAccess = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
